// File: rtl/multicycle_comparator_if.sv
// Handshake and operand bundle for multicycle_comparator.
// The master drives the start request and operands; the slave returns busy/done and the results.
interface multicycle_comparator_if #(
   parameter int BUS_SIZE = 32
);
   logic                in_start;
   logic [BUS_SIZE-1:0] in_a;
   logic [BUS_SIZE-1:0] in_b;
   logic [1:0]          in_mode;
   logic                out_busy;
   logic                out_done;
   logic                out_result;
   logic                out_is_equal;
   logic                out_is_not_equal;

   modport master (
      output in_start, in_a, in_b, in_mode,
      input  out_busy, out_done, out_result, out_is_equal, out_is_not_equal
   );

   modport slave (
      input  in_start, in_a, in_b, in_mode,
      output out_busy, out_done, out_result, out_is_equal, out_is_not_equal
   );
endinterface

// File: rtl/multicycle_comparator.sv
// Chunk-serial EQ/NE/LTU/LT comparator that scans operands MSB chunk first.
// Define MULTICYCLE_COMPARATOR_EARLY_EXIT_EN to stop at the first differing chunk.
module multicycle_comparator #(
   parameter int BUS_SIZE   = 32,
   parameter int CHUNK_SIZE = 8
) (
   input logic                    clk,
   input logic                    reset,
   multicycle_comparator_if.slave bus
);
   localparam int NUM_CHUNKS = BUS_SIZE / CHUNK_SIZE;
   localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   localparam logic [1:0] MODE_EQ  = 2'b00;
   localparam logic [1:0] MODE_NE  = 2'b01;
   localparam logic [1:0] MODE_LTU = 2'b10;
   localparam logic [1:0] MODE_LT  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t                                state;
   logic [NUM_CHUNKS-1:0][CHUNK_SIZE-1:0] a_q;
   logic [NUM_CHUNKS-1:0][CHUNK_SIZE-1:0] b_q;
   logic [1:0]                            mode_q;
   logic [IDX_W-1:0]                      index;
   logic                                  diff_seen;
   logic                                  diff_less;
   logic                                  busy_q;
   logic                                  done_q;
   logic                                  result_q;
   logic                                  equal_q;
   logic                                  not_equal_q;

   logic [CHUNK_SIZE-1:0] chunk_a;
   logic [CHUNK_SIZE-1:0] chunk_b;
   logic                  chunk_differ;
   logic                  chunk_less;
   logic                  last_chunk;
   logic                  decide;
   logic                  final_differ;
   logic                  final_less;
   logic                  result_next;

   // Signed order equals unsigned order once the sign bits are flipped, so LT only touches the top chunk.
   always_comb begin
      chunk_a = a_q[index];
      chunk_b = b_q[index];
      if (mode_q == MODE_LT && index == LAST_IDX) begin
         chunk_a[CHUNK_SIZE-1] = ~chunk_a[CHUNK_SIZE-1];
         chunk_b[CHUNK_SIZE-1] = ~chunk_b[CHUNK_SIZE-1];
      end
      chunk_differ = (chunk_a != chunk_b);
      chunk_less   = (chunk_a < chunk_b);
      last_chunk   = (index == '0);
      final_differ = diff_seen | chunk_differ;
      final_less   = diff_seen ? diff_less : chunk_less;
`ifdef MULTICYCLE_COMPARATOR_EARLY_EXIT_EN
      decide = chunk_differ | last_chunk;
`else
      decide = last_chunk;
`endif
      case (mode_q)
         MODE_EQ:  result_next = ~final_differ;
         MODE_NE:  result_next = final_differ;
         MODE_LTU: result_next = final_less;
         default:  result_next = final_less;
      endcase
   end

   // Without early exit the first difference is remembered while the scan runs to chunk 0.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         mode_q      <= MODE_EQ;
         index       <= '0;
         diff_seen   <= 1'b0;
         diff_less   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         result_q    <= 1'b0;
         equal_q     <= 1'b0;
         not_equal_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.in_start) begin
                  a_q       <= bus.in_a;
                  b_q       <= bus.in_b;
                  mode_q    <= bus.in_mode;
                  index     <= LAST_IDX;
                  diff_seen <= 1'b0;
                  diff_less <= 1'b0;
                  busy_q    <= 1'b1;
                  state     <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               if (chunk_differ && !diff_seen) begin
                  diff_seen <= 1'b1;
                  diff_less <= chunk_less;
               end
               if (decide) begin
                  result_q    <= result_next;
                  equal_q     <= ~final_differ;
                  not_equal_q <= final_differ;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  state       <= DONE;
               end else begin
                  index <= index - 1'b1;
               end
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.out_busy         = busy_q;
   assign bus.out_done         = done_q;
   assign bus.out_result       = result_q;
   assign bus.out_is_equal     = equal_q;
   assign bus.out_is_not_equal = not_equal_q;
endmodule

// File: tb/tb_multicycle_comparator.sv
// Scoreboard bench for multicycle_comparator: expectations are queued at start and checked at done.
module tb_multicycle_comparator;
   localparam int BUS_SIZE   = 32;
   localparam int CHUNK_SIZE = 8;
   localparam int NUM_CHUNKS = BUS_SIZE / CHUNK_SIZE;
`ifdef MULTICYCLE_COMPARATOR_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   localparam logic [1:0] EQ  = 2'b00;
   localparam logic [1:0] NE  = 2'b01;
   localparam logic [1:0] LTU = 2'b10;
   localparam logic [1:0] LT  = 2'b11;

   typedef struct {
      logic result;
      logic eq;
      logic ne;
      int   lat;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   multicycle_comparator_if #(.BUS_SIZE(BUS_SIZE)) bus ();

   multicycle_comparator #(
      .BUS_SIZE  (BUS_SIZE),
      .CHUNK_SIZE(CHUNK_SIZE)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] mode);
      exp_t e;
      int   first;
      first = -1;
      for (int i = NUM_CHUNKS - 1; i >= 0; i--) begin
         if (first < 0 && a[i*CHUNK_SIZE +: CHUNK_SIZE] != b[i*CHUNK_SIZE +: CHUNK_SIZE]) first = i;
      end
      e.eq = (a == b);
      e.ne = (a != b);
      case (mode)
         EQ:      e.result = (a == b);
         NE:      e.result = (a != b);
         LTU:     e.result = (a < b);
         default: e.result = ($signed(a) < $signed(b));
      endcase
      e.lat = (first < 0 || !EARLY) ? NUM_CHUNKS : 1 + (NUM_CHUNKS - 1 - first);
      return e;
   endfunction

   // Start is presented #1 after an edge, so the following edge is E0.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] mode);
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_mode  = mode;
      bus.in_start = 1'b1;
      sb.push_back(model(a, b, mode));
      @(posedge clk);
      #1;
      bus.in_start = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int busy_cnt, output bit timeout);
      lat      = 0;
      busy_cnt = 0;
      while (!bus.out_done && lat < 40) begin
         if (bus.out_busy) busy_cnt++;
         @(posedge clk);
         #1;
         lat++;
      end
      timeout = !bus.out_done;
   endtask

   task automatic test_reset();
      reset        = 1'b0;
      bus.in_start = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;
      bus.in_mode  = EQ;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.out_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.out_busy); end
      checks++; if (bus.out_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.out_done); end
      checks++; if (bus.out_result !== 1'b0) begin errors++; $display("[TB] FAIL reset_result: got %b expected 0", bus.out_result); end
      checks++; if (bus.out_is_equal !== 1'b0) begin errors++; $display("[TB] FAIL reset_eq: got %b expected 0", bus.out_is_equal); end
      checks++; if (bus.out_is_not_equal !== 1'b0) begin errors++; $display("[TB] FAIL reset_ne: got %b expected 0", bus.out_is_not_equal); end
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_vectors();
      logic [31:0] ta [10] = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678,
                               32'h0000_0001, 32'h00FF_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'h7FFF_FFFF};
      logic [31:0] tb_ [10] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 32'h1234_5678,
                               32'h8000_0000, 32'h00FE_0000, 32'h0000_0000, 32'h1234_5679, 32'h8000_0000};
      logic [1:0]  tm [10] = '{NE, NE, LTU, LT, EQ, LT, LTU, LT, LTU, LTU};
      logic [31:0] a, b;
      logic [1:0]  m;
      exp_t        e;
      int          lat, busy_cnt;
      bit          timeout;
      for (int i = 0; i < 18; i++) begin
         if (i < 10) begin
            a = ta[i]; b = tb_[i]; m = tm[i];
         end else begin
            a = $urandom;
            b = (i % 3 == 0) ? a : (a ^ (32'h1 << $urandom_range(31, 0)));
            m = 2'($urandom_range(3, 0));
         end
         issue(a, b, m);
         wait_done(lat, busy_cnt, timeout);
         e = sb.pop_front();
         checks++; if (timeout) begin errors++; $display("[TB] FAIL vec%0d_timeout: no done within 40 cycles", i); end
         checks++; if (lat !== e.lat) begin errors++; $display("[TB] FAIL vec%0d_latency: got %0d expected %0d", i, lat, e.lat); end
         checks++; if (busy_cnt !== e.lat) begin errors++; $display("[TB] FAIL vec%0d_busy_cycles: got %0d expected %0d", i, busy_cnt, e.lat); end
         checks++; if (bus.out_result !== e.result) begin errors++; $display("[TB] FAIL vec%0d_result: got %b expected %b", i, bus.out_result, e.result); end
         checks++; if (bus.out_is_equal !== e.eq) begin errors++; $display("[TB] FAIL vec%0d_eq: got %b expected %b", i, bus.out_is_equal, e.eq); end
         checks++; if (bus.out_is_not_equal !== e.ne) begin errors++; $display("[TB] FAIL vec%0d_ne: got %b expected %b", i, bus.out_is_not_equal, e.ne); end
         repeat (2) @(posedge clk);
         #1;
         checks++; if (bus.out_done !== 1'b0) begin errors++; $display("[TB] FAIL vec%0d_done_pulse: got %b expected 0", i, bus.out_done); end
         checks++; if (bus.out_result !== e.result) begin errors++; $display("[TB] FAIL vec%0d_result_hold: got %b expected %b", i, bus.out_result, e.result); end
      end
   endtask

   task automatic test_start_during_run();
      exp_t e;
      int   lat, busy_cnt;
      bit   timeout;
      issue(32'h1234_5678, 32'h1234_5678, EQ);
      bus.in_a     = 32'h0000_0000;
      bus.in_b     = 32'hFFFF_FFFF;
      bus.in_mode  = NE;
      bus.in_start = 1'b1;
      wait_done(lat, busy_cnt, timeout);
      bus.in_start = 1'b0;
      e = sb.pop_front();
      checks++; if (timeout) begin errors++; $display("[TB] FAIL run_start_timeout: no done within 40 cycles"); end
      checks++; if (lat !== e.lat) begin errors++; $display("[TB] FAIL run_start_latency: got %0d expected %0d", lat, e.lat); end
      checks++; if (busy_cnt !== e.lat) begin errors++; $display("[TB] FAIL run_start_busy_cycles: got %0d expected %0d", busy_cnt, e.lat); end
      checks++; if (bus.out_result !== e.result) begin errors++; $display("[TB] FAIL run_start_result: got %b expected %b", bus.out_result, e.result); end
      checks++; if (bus.out_is_equal !== e.eq) begin errors++; $display("[TB] FAIL run_start_eq: got %b expected %b", bus.out_is_equal, e.eq); end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   lat, busy_cnt;
      bit   timeout;
      issue(32'h8000_0000, 32'h0000_0001, LT);
      for (int k = 0; k < 3; k++) begin
         wait_done(lat, busy_cnt, timeout);
         e = sb.pop_front();
         checks++; if (timeout) begin errors++; $display("[TB] FAIL b2b%0d_timeout: no done within 40 cycles", k); end
         checks++; if (lat !== e.lat) begin errors++; $display("[TB] FAIL b2b%0d_latency: got %0d expected %0d", k, lat, e.lat); end
         checks++; if (busy_cnt !== e.lat) begin errors++; $display("[TB] FAIL b2b%0d_busy_cycles: got %0d expected %0d", k, busy_cnt, e.lat); end
         checks++; if (bus.out_result !== e.result) begin errors++; $display("[TB] FAIL b2b%0d_result: got %b expected %b", k, bus.out_result, e.result); end
         checks++; if (bus.out_is_not_equal !== e.ne) begin errors++; $display("[TB] FAIL b2b%0d_ne: got %b expected %b", k, bus.out_is_not_equal, e.ne); end
         if (k == 0) issue(32'h0000_0001, 32'h0000_0000, NE);
         if (k == 1) issue(32'h0000_0005, 32'h0000_0500, LTU);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_run();
      exp_t e;
      int   lat, busy_cnt, done_seen;
      bit   timeout;
      issue(32'h0000_0001, 32'h0000_0000, NE);
      wait_done(lat, busy_cnt, timeout);
      e = sb.pop_front();
      checks++; if (bus.out_result !== e.result) begin errors++; $display("[TB] FAIL pre_reset_result: got %b expected %b", bus.out_result, e.result); end
      @(posedge clk);
      #1;
      issue(32'h0000_0000, 32'h0000_0000, EQ);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      void'(sb.pop_back());
      checks++; if (bus.out_busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", bus.out_busy); end
      checks++; if (bus.out_result !== 1'b0) begin errors++; $display("[TB] FAIL midrst_result: got %b expected 0", bus.out_result); end
      checks++; if (bus.out_is_equal !== 1'b0) begin errors++; $display("[TB] FAIL midrst_eq: got %b expected 0", bus.out_is_equal); end
      checks++; if (bus.out_is_not_equal !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ne: got %b expected 0", bus.out_is_not_equal); end
      done_seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (bus.out_done || bus.out_busy) done_seen++;
         @(posedge clk);
         #1;
      end
      checks++; if (done_seen !== 0) begin errors++; $display("[TB] FAIL midrst_idle: got %0d active cycles expected 0", done_seen); end
      issue(32'hFFFF_FFFF, 32'h0000_0001, LT);
      wait_done(lat, busy_cnt, timeout);
      e = sb.pop_front();
      checks++; if (timeout) begin errors++; $display("[TB] FAIL post_reset_timeout: no done within 40 cycles"); end
      checks++; if (lat !== e.lat) begin errors++; $display("[TB] FAIL post_reset_latency: got %0d expected %0d", lat, e.lat); end
      checks++; if (bus.out_result !== e.result) begin errors++; $display("[TB] FAIL post_reset_result: got %b expected %b", bus.out_result, e.result); end
      checks++; if (bus.out_is_not_equal !== e.ne) begin errors++; $display("[TB] FAIL post_reset_ne: got %b expected %b", bus.out_is_not_equal, e.ne); end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_start_during_run();
      test_back_to_back();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
